// File: rtl/id_pkg.sv
// Shared decode types for the instruction-decode stage: control word,
// opcode set and the selector encodings used by the immediate and destination muxes.
package id_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;

  localparam logic [1:0] IMM_SEL_16 = 2'b00;
  localparam logic [1:0] IMM_SEL_19 = 2'b01;
  localparam logic [1:0] IMM_SEL_27 = 2'b10;

  localparam logic [1:0] REG_DST_RS1 = 2'b00;
  localparam logic [1:0] REG_DST_RS2 = 2'b01;
  localparam logic [1:0] REG_DST_RD  = 2'b10;

  typedef enum logic [4:0] {
    OP_ALU   = 5'd0,
    OP_ADDI  = 5'd2,
    OP_LOAD  = 5'd4,
    OP_STORE = 5'd6,
    OP_BEQ   = 5'd8,
    OP_JMP   = 5'd10,
    OP_CALL  = 5'd12,
    OP_RET   = 5'd14
  } id_opcode_e;

  typedef struct packed {
    logic       cmp;
    logic       returni;
    logic       mem_addr_sel;
    logic [1:0] sp_sel;
    logic       mem_wr;
    logic       wb_sel;
    logic       reg_wr;
    logic       call;
    logic [1:0] imm_sel;
    logic       branch_type;
    logic       branch_sel;
    logic [1:0] reg_dst_sel;
  } id_ctrl_t;

endpackage

// File: rtl/control_unit.sv
// Opcode to control-word decoder; unknown opcodes decode to an all-zero bubble.
module Control_Unit
  import id_pkg::*;
(
  input  logic [4:0] opcode,
  output id_ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ALU: begin
        ctrl.reg_wr      = 1'b1;
        ctrl.imm_sel     = IMM_SEL_16;
        ctrl.reg_dst_sel = REG_DST_RD;
      end
      OP_ADDI: begin
        ctrl.reg_wr      = 1'b1;
        ctrl.imm_sel     = IMM_SEL_16;
        ctrl.reg_dst_sel = REG_DST_RS1;
      end
      OP_LOAD: begin
        ctrl.mem_addr_sel = 1'b1;
        ctrl.wb_sel       = 1'b1;
        ctrl.reg_wr       = 1'b1;
        ctrl.reg_dst_sel  = REG_DST_RS2;
      end
      OP_STORE: begin
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_wr       = 1'b1;
      end
      OP_BEQ: begin
        ctrl.cmp         = 1'b1;
        ctrl.branch_type = 1'b1;
        ctrl.branch_sel  = 1'b1;
      end
      OP_JMP: begin
        ctrl.branch_sel = 1'b1;
        ctrl.imm_sel    = IMM_SEL_27;
      end
      OP_CALL: begin
        ctrl.call        = 1'b1;
        ctrl.sp_sel      = 2'b01;
        ctrl.mem_wr      = 1'b1;
        ctrl.branch_type = 1'b1;
        ctrl.branch_sel  = 1'b1;
        ctrl.imm_sel     = IMM_SEL_19;
      end
      OP_RET: begin
        ctrl.returni      = 1'b1;
        ctrl.sp_sel       = 2'b10;
        ctrl.mem_addr_sel = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_regfile_p.sv
// Architectural register file: two asynchronous read ports, one write port,
// synchronous active-low clear. No register is hard-wired to zero.
module id_regfile_p #(
  parameter  int XLEN = 32,
  parameter  int NREG = 16,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RAW-1:0]  rd_addr_a,
  input  logic [RAW-1:0]  rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  input  logic            wr_en,
  input  logic [RAW-1:0]  wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/id_stage_p.sv
// Pipelined decode stage: register read with forwarding, load-use stall,
// flush, branch-target generation and a registered ID/EX output with valid/ready.
module id_stage_p
  import id_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NREG    = 16,
  parameter  int NBYP    = 2,
  parameter  int RS1_LSB = 24,
  parameter  int RS2_LSB = 20,
  parameter  int RD_LSB  = 16,
  localparam int RAW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc_plus_4,
  input  logic                 in_interrupt,
  input  logic                 wb_wr,
  input  logic [RAW-1:0]       wb_dst,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [NBYP-1:0]      byp_valid,
  input  logic [NBYP-1:0]      byp_pending,
  input  logic [NBYP*RAW-1:0]  byp_dst,
  input  logic [NBYP*XLEN-1:0] byp_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1,
  output logic [XLEN-1:0]      out_rs2,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_pc_plus_4,
  output logic [RAW-1:0]       out_reg_dst,
  output logic [4:0]           out_opcode,
  output logic                 out_interrupt,
  output id_ctrl_t             out_ctrl,
  output logic [XLEN-1:0]      branch_pc,
  output logic                 branch_sel,
  output logic [31:0]          stall_cycles
);

  logic [4:0]      opcode;
  logic [RAW-1:0]  rs1, rs2, reg_dst;
  id_ctrl_t        ctrl;
  logic [XLEN-1:0] imm, rf_rs1, rf_rs2, rs1_val, rs2_val;
  logic            hazard, accept;

  assign opcode = in_instr[OPCODE_MSB:OPCODE_LSB];
  assign rs1    = in_instr[RS1_LSB +: RAW];
  assign rs2    = in_instr[RS2_LSB +: RAW];

  Control_Unit u_ctrl (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  id_regfile_p #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rs1),
    .rd_addr_b (rs2),
    .rd_data_a (rf_rs1),
    .rd_data_b (rf_rs2),
    .wr_en     (wb_wr),
    .wr_addr   (wb_dst),
    .wr_data   (wb_data)
  );

  always_comb begin
    case (ctrl.imm_sel)
      IMM_SEL_16: imm = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
      IMM_SEL_19: imm = {{(XLEN-19){in_instr[18]}}, in_instr[18:0]};
      default:    imm = {{(XLEN-27){in_instr[26]}}, in_instr[26:0]};
    endcase
  end

  always_comb begin
    case (ctrl.reg_dst_sel)
      REG_DST_RS1: reg_dst = rs1;
      REG_DST_RS2: reg_dst = rs2;
      default:     reg_dst = in_instr[RD_LSB +: RAW];
    endcase
  end

  // Lowest-priority source first, so later assignments (lower k) win.
  always_comb begin
    rs1_val = rf_rs1;
    rs2_val = rf_rs2;
    if (wb_wr && wb_dst == rs1) rs1_val = wb_data;
    if (wb_wr && wb_dst == rs2) rs2_val = wb_data;
    for (int k = NBYP - 1; k >= 0; k--) begin
      if (byp_valid[k] && !byp_pending[k] && byp_dst[k*RAW +: RAW] == rs1)
        rs1_val = byp_data[k*XLEN +: XLEN];
      if (byp_valid[k] && !byp_pending[k] && byp_dst[k*RAW +: RAW] == rs2)
        rs2_val = byp_data[k*XLEN +: XLEN];
    end
  end

  // Any pending source on either field stalls, even if a higher-priority one is ready.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NBYP; k++) begin
      if (in_valid && byp_valid[k] && byp_pending[k] &&
          (byp_dst[k*RAW +: RAW] == rs1 || byp_dst[k*RAW +: RAW] == rs2))
        hazard = 1'b1;
    end
  end

  assign in_ready   = rst_n && (flush || ((!out_valid || out_ready) && !hazard));
  assign accept     = in_valid && in_ready && !flush;
  assign branch_pc  = imm + (ctrl.branch_type ? in_pc_plus_4 : '0);
  assign branch_sel = ctrl.branch_sel && accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_imm       <= '0;
      out_pc_plus_4 <= '0;
      out_reg_dst   <= '0;
      out_opcode    <= '0;
      out_interrupt <= 1'b0;
      out_ctrl      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_rs1       <= rs1_val;
      out_rs2       <= rs2_val;
      out_imm       <= imm;
      out_pc_plus_4 <= in_pc_plus_4;
      out_reg_dst   <= reg_dst;
      out_opcode    <= opcode;
      out_interrupt <= in_interrupt;
      out_ctrl      <= ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (in_valid && !in_ready && !flush && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_id_stage_p.sv
// Directed test for id_stage_p: reset, write-through, forwarding priority,
// load-use stall, backpressure, branch target generation and flush.
module tb_id_stage_p;
  import id_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc_plus_4;
  logic        in_interrupt;
  logic        wb_wr;
  logic [3:0]  wb_dst;
  logic [31:0] wb_data;
  logic [1:0]  byp_valid;
  logic [1:0]  byp_pending;
  logic [7:0]  byp_dst;
  logic [63:0] byp_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1, out_rs2, out_imm, out_pc_plus_4;
  logic [3:0]  out_reg_dst;
  logic [4:0]  out_opcode;
  logic        out_interrupt;
  id_ctrl_t    out_ctrl;
  logic [31:0] branch_pc;
  logic        branch_sel;
  logic [31:0] stall_cycles;

  int tests_run;
  int tests_failed;

  id_stage_p dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc_plus_4  (in_pc_plus_4),
    .in_interrupt  (in_interrupt),
    .wb_wr         (wb_wr),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .byp_valid     (byp_valid),
    .byp_pending   (byp_pending),
    .byp_dst       (byp_dst),
    .byp_data      (byp_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_reg_dst   (out_reg_dst),
    .out_opcode    (out_opcode),
    .out_interrupt (out_interrupt),
    .out_ctrl      (out_ctrl),
    .branch_pc     (branch_pc),
    .branch_sel    (branch_sel),
    .stall_cycles  (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mkInstr(input logic [4:0] op, input logic [3:0] rs1,
                                          input logic [3:0] rs2, input logic [3:0] rd,
                                          input logic [15:0] imm16);
    logic [31:0] r;
    r = {op, 27'd0};
    r = r | (32'(rs1) << 24) | (32'(rs2) << 20) | (32'(rd) << 16) | 32'(imm16);
    return r;
  endfunction

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc4);
    in_valid     = valid;
    in_instr     = instr;
    in_pc_plus_4 = pc4;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_interrupt = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b1;
    byp_valid    = '0;
    byp_pending  = '0;
    byp_dst      = '0;
    byp_data     = '0;
    wb_wr        = 1'b1;
    wb_dst       = 4'd4;
    wb_data      = 32'h0000_AAAA;
    applyStimulus(1'b1, {5'd10, 27'h0000010}, 32'h40);

    // Reset: writes and the in-flight jump must leave no trace.
    #1;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_branch_sel", branch_sel, 0);
    nextCycle();
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_rs1", out_rs1, 0);
    checkOutput("reset_out_ctrl", out_ctrl, 0);
    checkOutput("reset_stall", stall_cycles, 0);
    nextCycle();
    checkOutput("reset_out_imm", out_imm, 0);
    checkOutput("reset_out_pc4", out_pc_plus_4, 0);

    // Write-through of r3 while decoding rs1 = 3; r4 write during reset was dropped.
    rst_n   = 1'b1;
    wb_wr   = 1'b1;
    wb_dst  = 4'd3;
    wb_data = 32'hDEAD_BEEF;
    applyStimulus(1'b1, mkInstr(OP_ALU, 4'd3, 4'd4, 4'd7, 16'h0), 32'h40);
    #1;
    checkOutput("wt_in_ready", in_ready, 1);
    nextCycle();
    checkOutput("wt_out_valid", out_valid, 1);
    checkOutput("wt_out_rs1", out_rs1, 32'hDEAD_BEEF);
    checkOutput("wt_out_rs2_r4", out_rs2, 0);
    checkOutput("wt_reg_dst", out_reg_dst, 7);
    checkOutput("wt_pc4", out_pc_plus_4, 32'h40);

    // Forward priority: byp[0] beats byp[1] beats write-back.
    wb_dst      = 4'd5;
    wb_data     = 32'h33;
    byp_valid   = 2'b11;
    byp_dst     = {4'd5, 4'd5};
    byp_data    = {32'h22, 32'h11};
    applyStimulus(1'b1, mkInstr(OP_ADDI, 4'd3, 4'd5, 4'd0, 16'h8000), 32'h44);
    nextCycle();
    checkOutput("fwd_byp0", out_rs2, 32'h11);
    checkOutput("fwd_rs1_array", out_rs1, 32'hDEAD_BEEF);
    checkOutput("fwd_imm", out_imm, 32'hFFFF_8000);
    checkOutput("fwd_reg_dst_rs1", out_reg_dst, 3);
    byp_valid = 2'b10;
    nextCycle();
    checkOutput("fwd_byp1", out_rs2, 32'h22);
    byp_valid = 2'b00;
    wb_data   = 32'h44;
    nextCycle();
    checkOutput("fwd_wb_through", out_rs2, 32'h44);
    wb_wr = 1'b0;
    nextCycle();
    checkOutput("fwd_array_r5", out_rs2, 32'h44);

    // Load-use: byp[0] pending on r2 for three cycles.
    byp_valid   = 2'b01;
    byp_pending = 2'b01;
    byp_dst     = {4'd0, 4'd2};
    byp_data    = {32'h0, 32'h77};
    applyStimulus(1'b1, mkInstr(OP_LOAD, 4'd2, 4'd1, 4'd0, 16'h0010), 32'h48);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("lu_in_ready_low", in_ready, 0);
      nextCycle();
    end
    checkOutput("lu_stall3", stall_cycles, 3);
    checkOutput("lu_bubble", out_valid, 0);
    byp_pending = 2'b00;
    #1;
    checkOutput("lu_in_ready_high", in_ready, 1);
    nextCycle();
    checkOutput("lu_out_valid", out_valid, 1);
    checkOutput("lu_out_rs1", out_rs1, 32'h77);
    checkOutput("lu_out_rs2", out_rs2, 0);
    checkOutput("lu_reg_dst_rs2", out_reg_dst, 1);
    checkOutput("lu_stall_hold", stall_cycles, 3);

    // Backpressure: outputs frozen for four cycles.
    byp_valid = 2'b00;
    out_ready = 1'b0;
    applyStimulus(1'b1, mkInstr(OP_ALU, 4'd3, 4'd6, 4'd7, 16'h0), 32'h4C);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("bp_in_ready", in_ready, 0);
      nextCycle();
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_out_rs1", out_rs1, 32'h77);
      checkOutput("bp_out_imm", out_imm, 32'h10);
    end
    checkOutput("bp_stall7", stall_cycles, 7);

    // Hazard still raised when byp[0] is ready but byp[1] pends on rs1.
    out_ready   = 1'b1;
    byp_valid   = 2'b11;
    byp_pending = 2'b10;
    byp_dst     = {4'd3, 4'd3};
    byp_data    = {32'h0, 32'h99};
    #1;
    checkOutput("hz_shadowed_pending", in_ready, 0);
    nextCycle();
    // Pending producer matched only through the rs2 field.
    byp_valid   = 2'b01;
    byp_pending = 2'b01;
    byp_dst     = {4'd0, 4'd6};
    #1;
    checkOutput("hz_rs2_field", in_ready, 0);
    nextCycle();
    checkOutput("hz_stall9", stall_cycles, 9);
    byp_valid   = 2'b00;
    byp_pending = 2'b00;
    nextCycle();
    checkOutput("hz_accept_rs1", out_rs1, 32'hDEAD_BEEF);
    checkOutput("hz_accept_valid", out_valid, 1);

    // Branch: imm -4 plus PC+4 0x100.
    applyStimulus(1'b1, mkInstr(OP_BEQ, 4'd0, 4'd0, 4'd0, 16'hFFFC), 32'h100);
    #1;
    checkOutput("br_pc", branch_pc, 32'hFC);
    checkOutput("br_sel", branch_sel, 1);
    nextCycle();
    checkOutput("br_out_pc4", out_pc_plus_4, 32'h100);
    checkOutput("br_out_ctrl_sel", out_ctrl.branch_sel, 1);

    // Same branch with flush: no redirect, stage empties.
    flush = 1'b1;
    #1;
    checkOutput("fl_branch_sel", branch_sel, 0);
    checkOutput("fl_in_ready", in_ready, 1);
    nextCycle();
    checkOutput("fl_out_valid", out_valid, 0);
    // Flush overlapping a load-use hazard is not a stall.
    byp_valid   = 2'b01;
    byp_pending = 2'b01;
    byp_dst     = {4'd0, 4'd0};
    #1;
    checkOutput("fl_hz_in_ready", in_ready, 1);
    nextCycle();
    checkOutput("fl_stall_hold", stall_cycles, 9);
    checkOutput("fl_out_valid2", out_valid, 0);

    // Jump: 27-bit immediate, no PC add.
    flush       = 1'b0;
    byp_valid   = 2'b00;
    byp_pending = 2'b00;
    applyStimulus(1'b1, {5'd10, 27'h4000010}, 32'h200);
    #1;
    checkOutput("jmp_pc", branch_pc, 32'hFC00_0010);
    checkOutput("jmp_sel", branch_sel, 1);
    nextCycle();
    checkOutput("jmp_out_opcode", out_opcode, 10);

    // Call: 19-bit immediate plus PC+4.
    applyStimulus(1'b1, {5'd12, 27'h0040004}, 32'h100);
    #1;
    checkOutput("call_pc", branch_pc, 32'hFFFC_0104);
    nextCycle();
    checkOutput("call_out_imm", out_imm, 32'hFFFC_0004);

    applyStimulus(1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("drain_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
